// File: rtl/picc_tx_scheduler.sv
// Round-robin scheduler that shares one picc_to_pcd transmitter among several
// PICC response sources, enforcing the frame guard time and tracking tx busy.
module picc_tx_scheduler #(
    parameter int NUM_REQ      = 3,
    parameter int GUARD_CYCLES = 11720,
    parameter int BUSY_TIMEOUT = 2048
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [NUM_REQ-1:0]    req_in,
    input  logic [NUM_REQ*40-1:0] data_in,
    input  logic [NUM_REQ*3-1:0]  num_bytes_in,
    output logic [NUM_REQ-1:0]    grant_out,
    output logic [NUM_REQ-1:0]    done_out,
    output logic                  err_out,
    output logic [39:0]           tx_data_out,
    output logic [2:0]            tx_num_bytes_out,
    output logic                  tx_trigger_out,
    input  logic                  tx_busy_in,
    output logic                  busy_out
);

    localparam int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_MAX = (GUARD_CYCLES > BUSY_TIMEOUT) ? GUARD_CYCLES : BUSY_TIMEOUT;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GUARD     = 3'd1,
        ST_TRIG      = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_ACTIVE    = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    // Returns {found, index} of the first set request at or after ptr, wrapping.
    function automatic logic [PW:0] pick_winner(input logic [NUM_REQ-1:0] req,
                                                input logic [PW-1:0]      ptr);
        logic [PW:0] pick;
        int          idx;
        pick = {(PW+1){1'b0}};
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (req[idx]) begin
                pick = {1'b1, PW'(idx)};
            end
        end
        return pick;
    endfunction

    state_t               state_r, next_state_s;
    logic [PW-1:0]        ptr_r, ptr_nxt_s;
    logic [CW-1:0]        cnt_r, cnt_nxt_s;
    logic [PW:0]          pick_s;
    logic                 win_found_s;
    logic [PW-1:0]        win_idx_s;
    logic [NUM_REQ-1:0]   win_onehot_s;
    logic [39:0]          win_data_s;
    logic [2:0]           win_nb_s;
    logic                 win_len_ok_s;
    logic                 load_s;
    logic [NUM_REQ-1:0]   grant_nxt_s, done_nxt_s;
    logic                 err_nxt_s, trig_nxt_s, busy_nxt_s;
    logic [NUM_REQ-1:0]   grant_r, done_r;
    logic                 err_r, trig_r, busy_r;
    logic [39:0]          tx_data_r;
    logic [2:0]           tx_nb_r;

    assign pick_s       = pick_winner(req_in, ptr_r);
    assign win_found_s  = pick_s[PW];
    assign win_idx_s    = pick_s[PW-1:0];
    assign win_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_s;
    assign win_data_s   = data_in[40*int'(win_idx_s) +: 40];
    assign win_nb_s     = num_bytes_in[3*int'(win_idx_s) +: 3];
    assign win_len_ok_s = (win_nb_s != 3'd0) && (win_nb_s <= 3'd5);

    // State register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    next_state_s = win_len_ok_s ? ST_GUARD : ST_DONE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_GUARD: begin
                if (cnt_r == {CW{1'b0}}) begin
                    next_state_s = ST_TRIG;
                end else begin
                    next_state_s = ST_GUARD;
                end
            end
            ST_TRIG:      next_state_s = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (tx_busy_in) begin
                    next_state_s = ST_ACTIVE;
                end else if (cnt_r == {CW{1'b0}}) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_WAIT_BUSY;
                end
            end
            ST_ACTIVE: begin
                if (!tx_busy_in) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_ACTIVE;
                end
            end
            ST_DONE:      next_state_s = ST_IDLE;
            default:      next_state_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, counter and pointer.
    always_comb begin
        grant_nxt_s = grant_r;
        done_nxt_s  = {NUM_REQ{1'b0}};
        err_nxt_s   = 1'b0;
        trig_nxt_s  = 1'b0;
        load_s      = 1'b0;
        cnt_nxt_s   = cnt_r;
        ptr_nxt_s   = ptr_r;
        busy_nxt_s  = (next_state_s != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    grant_nxt_s = win_onehot_s;
                    load_s      = 1'b1;
                    if (int'(win_idx_s) == NUM_REQ - 1) begin
                        ptr_nxt_s = {PW{1'b0}};
                    end else begin
                        ptr_nxt_s = win_idx_s + PW'(1);
                    end
                    if (win_len_ok_s) begin
                        cnt_nxt_s = CW'(GUARD_CYCLES);
                    end else begin
                        err_nxt_s  = 1'b1;
                        done_nxt_s = win_onehot_s;
                    end
                end else begin
                    grant_nxt_s = {NUM_REQ{1'b0}};
                end
            end
            ST_GUARD: begin
                if (cnt_r != {CW{1'b0}}) begin
                    cnt_nxt_s = cnt_r - CW'(1);
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_TRIG: begin
                trig_nxt_s = 1'b1;
                cnt_nxt_s  = CW'(BUSY_TIMEOUT);
            end
            ST_WAIT_BUSY: begin
                if (tx_busy_in) begin
                    cnt_nxt_s = cnt_r;
                end else if (cnt_r == {CW{1'b0}}) begin
                    err_nxt_s  = 1'b1;
                    done_nxt_s = grant_r;
                end else begin
                    cnt_nxt_s = cnt_r - CW'(1);
                end
            end
            ST_ACTIVE: begin
                if (!tx_busy_in) begin
                    done_nxt_s = grant_r;
                end else begin
                    done_nxt_s = {NUM_REQ{1'b0}};
                end
            end
            ST_DONE:  grant_nxt_s = {NUM_REQ{1'b0}};
            default:  grant_nxt_s = {NUM_REQ{1'b0}};
        endcase
    end

    // Output, datapath, counter and pointer registers; reset abandons any frame silently.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            grant_r   <= {NUM_REQ{1'b0}};
            done_r    <= {NUM_REQ{1'b0}};
            err_r     <= 1'b0;
            trig_r    <= 1'b0;
            busy_r    <= 1'b0;
            tx_data_r <= 40'h0;
            tx_nb_r   <= 3'd0;
            cnt_r     <= {CW{1'b0}};
            ptr_r     <= {PW{1'b0}};
        end else begin
            grant_r <= grant_nxt_s;
            done_r  <= done_nxt_s;
            err_r   <= err_nxt_s;
            trig_r  <= trig_nxt_s;
            busy_r  <= busy_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ptr_r   <= ptr_nxt_s;
            if (load_s) begin
                tx_data_r <= win_data_s;
                tx_nb_r   <= win_nb_s;
            end
        end
    end

    assign grant_out        = grant_r;
    assign done_out         = done_r;
    assign err_out          = err_r;
    assign tx_trigger_out   = trig_r;
    assign busy_out         = busy_r;
    assign tx_data_out      = tx_data_r;
    assign tx_num_bytes_out = tx_nb_r;

endmodule

// File: tb/tb_picc_tx_scheduler.sv
// Directed bench for picc_tx_scheduler with a queue of expected grants.
module tb_picc_tx_scheduler;

    localparam int N  = 3;
    localparam int G  = 4;
    localparam int BT = 8;

    logic           clk_in = 1'b0;
    logic           rst_in = 1'b0;
    logic [N-1:0]   req_in;
    logic [N*40-1:0] data_in;
    logic [N*3-1:0] num_bytes_in;
    logic [N-1:0]   grant_out, done_out;
    logic           err_out, tx_trigger_out, tx_busy_in, busy_out;
    logic [39:0]    tx_data_out;
    logic [2:0]     tx_num_bytes_out;

    picc_tx_scheduler #(.NUM_REQ(N), .GUARD_CYCLES(G), .BUSY_TIMEOUT(BT)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .req_in          (req_in),
        .data_in         (data_in),
        .num_bytes_in    (num_bytes_in),
        .grant_out       (grant_out),
        .done_out        (done_out),
        .err_out         (err_out),
        .tx_data_out     (tx_data_out),
        .tx_num_bytes_out(tx_num_bytes_out),
        .tx_trigger_out  (tx_trigger_out),
        .tx_busy_in      (tx_busy_in),
        .busy_out        (busy_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          idx;
        logic [39:0] data;
        logic [2:0]  nb;
        bit          err;
    } exp_t;

    exp_t sb_q[$];
    int vectors     = 0;
    int miscompares = 0;
    int trig_count  = 0;
    int err_count   = 0;
    int done_count  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        if (tx_trigger_out) trig_count++;
        if (err_out) err_count++;
        if (done_out != 3'b000) done_count++;
    endtask

    task automatic set_req(input int i, input logic [39:0] d, input logic [2:0] nb);
        data_in[40*i +: 40] = d;
        num_bytes_in[3*i +: 3] = nb;
        req_in[i] = 1'b1;
    endtask

    task automatic push_exp(input int i, input logic [39:0] d, input logic [2:0] nb);
        exp_t e;
        e.idx  = i;
        e.data = d;
        e.nb   = nb;
        e.err  = (nb == 3'd0) || (nb > 3'd5);
        sb_q.push_back(e);
    endtask

    // busy_delay < 0 models a transmitter that never raises busy.
    task automatic serve(input int busy_delay, input int busy_len, input logic [2:0] drop_mask);
        exp_t        e;
        int          n;
        int          trig0, err0;
        logic [2:0]  oh;
        n = 0;
        while (grant_out == 3'b000 && n < 50) begin
            tick();
            n++;
        end
        check("grant_seen", 64'(grant_out != 3'b000), 64'd1);
        check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
        if (grant_out == 3'b000 || sb_q.size() == 0) return;
        e  = sb_q.pop_front();
        oh = 3'b001 << e.idx;
        check("grant_onehot", 64'(grant_out), 64'(oh));
        check("tx_data", 64'(tx_data_out), 64'(e.data));
        check("tx_nbytes", 64'(tx_num_bytes_out), 64'(e.nb));
        check("busy_out_on", 64'(busy_out), 64'd1);
        trig0 = trig_count;
        err0  = err_count;
        if (e.err) begin
            check("rej_err", 64'(err_out), 64'd1);
            check("rej_done", 64'(done_out), 64'(oh));
            req_in = req_in & ~drop_mask;
            tick();
            check("rej_idle", 64'(busy_out), 64'd0);
            check("rej_grant_clr", 64'(grant_out), 64'd0);
            check("rej_no_trig", 64'(trig_count - trig0), 64'd0);
            return;
        end
        check("grant_no_err", 64'(err_out), 64'd0);
        n = 0;
        while (!tx_trigger_out && n < 50) begin
            tick();
            n++;
        end
        check("grant_to_trig", 64'(n), 64'(G + 2));
        tick();
        check("trig_one_cycle", 64'(tx_trigger_out), 64'd0);
        if (busy_delay < 0) begin
            repeat (BT - 1) tick();
            check("to_no_early_done", 64'(done_out), 64'd0);
            tick();
            check("to_done", 64'(done_out), 64'(oh));
            check("to_err", 64'(err_out), 64'd1);
            check("to_err_count", 64'(err_count - err0), 64'd1);
        end else begin
            repeat (busy_delay - 1) tick();
            tx_busy_in = 1'b1;
            repeat (busy_len) tick();
            check("active_no_done", 64'(done_out), 64'd0);
            tx_busy_in = 1'b0;
            tick();
            check("done_pulse", 64'(done_out), 64'(oh));
            check("done_grant_held", 64'(grant_out), 64'(oh));
            check("no_err", 64'(err_count - err0), 64'd0);
        end
        check("one_trig", 64'(trig_count - trig0), 64'd1);
        req_in = req_in & ~drop_mask;
        tick();
        check("end_grant_clr", 64'(grant_out), 64'd0);
        check("end_done_clr", 64'(done_out), 64'd0);
        check("end_idle", 64'(busy_out), 64'd0);
        check("data_latched", 64'(tx_data_out), 64'(e.data));
    endtask

    initial begin
        int n;
        int done0;
        req_in       = 3'b000;
        data_in      = 120'h0;
        num_bytes_in = 9'h0;
        tx_busy_in   = 1'b0;

        #12;
        check("rst_grant", 64'(grant_out), 64'd0);
        check("rst_done", 64'(done_out), 64'd0);
        check("rst_err", 64'(err_out), 64'd0);
        check("rst_trig", 64'(tx_trigger_out), 64'd0);
        check("rst_busy", 64'(busy_out), 64'd0);
        check("rst_data", 64'(tx_data_out), 64'd0);
        check("rst_nbytes", 64'(tx_num_bytes_out), 64'd0);
        @(negedge clk_in);
        rst_in = 1'b1;

        // Fairness with all three requesters held high.
        set_req(0, 40'h1000000001, 3'd1);
        set_req(1, 40'h2000000002, 3'd2);
        set_req(2, 40'h3000000003, 3'd3);
        push_exp(0, 40'h1000000001, 3'd1);
        push_exp(1, 40'h2000000002, 3'd2);
        push_exp(2, 40'h3000000003, 3'd3);
        push_exp(0, 40'h1000000001, 3'd1);
        serve(2, 3, 3'b000);
        serve(2, 3, 3'b000);
        serve(2, 3, 3'b000);
        serve(2, 3, 3'b111);

        // Single request, 4 bytes.
        set_req(0, 40'h2490673500, 3'd4);
        push_exp(0, 40'h2490673500, 3'd4);
        serve(5, 20, 3'b001);

        // Invalid lengths on requester 1.
        set_req(1, 40'h1111111111, 3'd0);
        push_exp(1, 40'h1111111111, 3'd0);
        serve(1, 1, 3'b010);
        set_req(1, 40'h2222222222, 3'd6);
        push_exp(1, 40'h2222222222, 3'd6);
        serve(1, 1, 3'b010);

        // Busy timeout, then a normal transfer.
        set_req(2, 40'hA5A5A5A5A5, 3'd2);
        push_exp(2, 40'hA5A5A5A5A5, 3'd2);
        serve(-1, 0, 3'b100);
        set_req(0, 40'h0F1E2D3C4B, 3'd5);
        push_exp(0, 40'h0F1E2D3C4B, 3'd5);
        serve(3, 4, 3'b001);

        // Transmitter busy while idle is ignored.
        tx_busy_in = 1'b1;
        repeat (3) tick();
        check("idle_busy_ignored", 64'(busy_out), 64'd0);
        tx_busy_in = 1'b0;
        tick();

        // Asynchronous reset while ACTIVE.
        set_req(0, 40'hDEADBEEF01, 3'd3);
        n = 0;
        while (!tx_trigger_out && n < 50) begin
            tick();
            n++;
        end
        check("rstt_trig_seen", 64'(tx_trigger_out), 64'd1);
        tick();
        tx_busy_in = 1'b1;
        repeat (4) tick();
        check("rstt_active", 64'(busy_out), 64'd1);
        done0 = done_count;
        #3;
        rst_in = 1'b0;
        #1;
        check("arst_grant", 64'(grant_out), 64'd0);
        check("arst_done", 64'(done_out), 64'd0);
        check("arst_err", 64'(err_out), 64'd0);
        check("arst_busy", 64'(busy_out), 64'd0);
        check("arst_data", 64'(tx_data_out), 64'd0);
        tx_busy_in = 1'b0;
        req_in     = 3'b000;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        tick();
        check("arst_no_done", 64'(done_count - done0), 64'd0);
        set_req(0, 40'h0102030405, 3'd5);
        set_req(1, 40'h0A0B0C0D0E, 3'd1);
        push_exp(0, 40'h0102030405, 3'd5);
        push_exp(1, 40'h0A0B0C0D0E, 3'd1);
        serve(2, 2, 3'b001);
        serve(2, 2, 3'b010);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/picc_tx_scheduler.md
Name: picc_tx_scheduler

Overview:
- Arbiter and sequencer that shares one picc_to_pcd transmitter among several PICC response sources (ATQA, anticollision/UID, SAK, ...).
- Selects one pending request round-robin, latches its frame and enforces the PICC frame delay guard time.
- Fires a single trigger pulse to the transmitter, tracks its busy signal through to completion, then acknowledges the requester.
- Sits between the protocol logic and picc_to_pcd in the 135.6 MHz clk_in domain.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- GUARD_CYCLES, 11720, clk_in cycles from grant to trigger (about 1172/fc at 135.6 MHz); 0 is legal.
- BUSY_TIMEOUT, 2048, clk_in cycles allowed for tx_busy_in to rise after trigger.

Ports:
- clk_in  input  1  system clock, 135.6 MHz.
- rst_in  input  1  asynchronous, active-low reset.
- req_in  input  NUM_REQ  per-requester request level; held until the matching done_out.
- data_in  input  NUM_REQ*40  per-requester frame bytes; slice i = [40*i+39:40*i].
- num_bytes_in  input  NUM_REQ*3  per-requester byte count; slice i = [3*i+2:3*i].
- grant_out  output  NUM_REQ  one-hot; the bit of the requester being serviced.
- done_out  output  NUM_REQ  one-cycle completion pulse to that requester.
- err_out  output  1  one-cycle pulse on a rejected or timed-out request.
- tx_data_out  output  40  frame data to the transmitter.
- tx_num_bytes_out  output  3  byte count to the transmitter.
- tx_trigger_out  output  1  one-cycle start pulse to the transmitter.
- tx_busy_in  input  1  transmitter busy.
- busy_out  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst_in=0, asynchronous): state IDLE and round-robin pointer = 0.
- Reset values: all outputs 0, including tx_data_out and tx_num_bytes_out.
- Reset mid-frame: abandon immediately; no done_out or err_out is produced.
- FSM states: IDLE, GUARD, TRIG, WAIT_BUSY, ACTIVE, DONE.
- IDLE, arbitration:
  - When any req_in bit is high, pick the first set bit at or after the pointer, wrapping around.
  - Latch that requester's data/num_bytes into tx_data_out/tx_num_bytes_out and set grant_out.
  - If num_bytes is 0 or greater than 5: pulse err_out and done_out for the winner, skip transmission, go to DONE.
  - Otherwise load the guard counter with GUARD_CYCLES and go to GUARD.
- Pointer: advances to winner+1 (mod NUM_REQ) on every grant, accepted or rejected.
- GUARD: decrement the counter each cycle; at 0 go to TRIG. With GUARD_CYCLES=0, GUARD lasts exactly 1 cycle.
- TRIG: tx_trigger_out=1 for exactly one cycle; load the timeout counter with BUSY_TIMEOUT; go to WAIT_BUSY.
- WAIT_BUSY:
  - tx_busy_in=1 → ACTIVE.
  - Counter reaches 0 first → pulse err_out and done_out, go to DONE.
- ACTIVE: on tx_busy_in=0 (falling edge relative to ACTIVE entry), pulse done_out for the granted requester and go to DONE.
- DONE:
  - Clear grant_out and return to IDLE.
  - This gives a single cycle of requester turnaround, so a req_in still high in this cycle is not re-arbitrated yet.
- Grant lifetime: grant_out holds from the grant cycle through the done_out cycle.
- Latched values: tx_data_out/tx_num_bytes_out stay stable until the next grant.
- Requests outside IDLE: req_in changes outside IDLE are ignored. A requester dropping req_in while granted does not abort the transfer; done_out is still pulsed.
- Simultaneous requests: exactly one grant per arbitration; the others wait.
- Latency: grant to trigger = GUARD_CYCLES+2 clk_in cycles (GUARD plus TRIG entry).
- tx_busy_in already high in IDLE: ignored; only the WAIT_BUSY/ACTIVE sequence matters.

Test Plan:
- Single request: GUARD_CYCLES=4, req_in=3'b001, data=40'h24_90_67_35_00, nbytes=4; busy high 5 cycles after trigger for 20 cycles.
  → tx_trigger_out pulses 6 cycles after grant; tx_data_out=40'h2490673500; done_out[0] pulses when busy falls; err_out stays 0.
- Fairness: req_in=3'b111 held continuously, busy modelled.
  → grants in order 0,1,2,0; each grant is one-hot; exactly one trigger per grant.
- Invalid length: nbytes=0 on requester 1, then nbytes=6.
  → err_out and done_out[1] pulse, no tx_trigger_out, return to IDLE in 2 cycles.
- Timeout: BUSY_TIMEOUT=8, busy never asserted.
  → err_out and done_out pulse 9 cycles after trigger; the next request is served normally.
- Async reset mid-ACTIVE: rst_in low between clock edges.
  → outputs go to 0 immediately with no done_out; after release, the pointer is 0 so requester 0 wins a 3'b011 request.
